// File: rtl/monster_collision_detector.sv
// -----------------------------------------------------------------------------
// monster_collision_detector
//
// Detects monster/wall and monster/player pixel overlaps in the pixel stream.
//
// Wall path: every overlap pixel ORs the monster edge code into a per-frame
// accumulator. On startOfFrame the accumulated code is published for a whole
// frame, and a single monsterWallHit pulse is raised if any overlap was seen.
// Player path: a READY/HOLDOFF state machine accepts one player hit, then
// ignores further hits for HOLDOFF_FRAMES frames.
//
// Ports
//   clk                    pixel clock
//   resetN                 asynchronous active-low reset
//   startOfFrame           one-cycle pulse on the first pixel of a frame
//   monsterDrawingRequest  monster pixel opaque
//   monsterHitEdgeCode     monster edge code {Left, Top, Right, Bottom}
//   wallDrawingRequest     wall pixel opaque
//   playerDrawingRequest   player pixel opaque
//   monsterWallHit         one-cycle pulse: previous frame had a wall overlap
//   wallHitEdgeCode        OR of overlap edge codes of the previous frame
//   playerHit              one-cycle pulse on an accepted player hit
//   holdoffActive          high while player hits are suppressed
//   hitCount               saturating count of accepted player hits
// -----------------------------------------------------------------------------
module monster_collision_detector #(
  parameter int HOLDOFF_FRAMES = 4,
  parameter int EDGE_CODE_W    = 4
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   monsterDrawingRequest,
  input  logic [EDGE_CODE_W-1:0] monsterHitEdgeCode,
  input  logic                   wallDrawingRequest,
  input  logic                   playerDrawingRequest,
  output logic                   monsterWallHit,
  output logic [EDGE_CODE_W-1:0] wallHitEdgeCode,
  output logic                   playerHit,
  output logic                   holdoffActive,
  output logic [7:0]             hitCount
);

  localparam logic [3:0] HOLDOFF_INIT = 4'(HOLDOFF_FRAMES);

  typedef enum logic {
    READY   = 1'b0,
    HOLDOFF = 1'b1
  } hit_state_t;

  logic                   wall_overlap;
  logic                   player_overlap;
  logic [EDGE_CODE_W-1:0] edge_acc;
  logic                   wall_seen;
  hit_state_t             state;
  logic [3:0]             frame_cnt;

  assign wall_overlap   = monsterDrawingRequest && wallDrawingRequest;
  assign player_overlap = monsterDrawingRequest && playerDrawingRequest;

  // Wall path. An overlap on the startOfFrame pixel belongs to the new frame,
  // so it seeds the accumulator instead of being merged into the publish.
  // NOTE: every register here uses <= so that the publish reads the
  // accumulator value from before this edge, not the freshly cleared one.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      edge_acc        <= '0;
      wall_seen       <= 1'b0;
      monsterWallHit  <= 1'b0;
      wallHitEdgeCode <= '0;
    end else if (startOfFrame) begin
      wallHitEdgeCode <= edge_acc;
      monsterWallHit  <= wall_seen;
      edge_acc        <= wall_overlap ? monsterHitEdgeCode : '0;
      wall_seen       <= wall_overlap;
    end else begin
      monsterWallHit <= 1'b0;
      if (wall_overlap) begin
        edge_acc  <= edge_acc | monsterHitEdgeCode;
        wall_seen <= 1'b1;
      end
    end
  end

  // Player path. Entering HOLDOFF blocks the remaining pixels of a long
  // overlap run, so a run yields a single pulse. The frame on which the
  // counter expires is still HOLDOFF, so an overlap on that pixel is ignored.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= READY;
      frame_cnt     <= '0;
      playerHit     <= 1'b0;
      holdoffActive <= 1'b0;
      hitCount      <= '0;
    end else begin
      playerHit <= 1'b0;
      case (state)
        READY: begin
          if (player_overlap) begin
            playerHit     <= 1'b1;
            holdoffActive <= 1'b1;
            frame_cnt     <= HOLDOFF_INIT;
            state         <= HOLDOFF;
            if (hitCount != 8'hFF) hitCount <= hitCount + 8'd1;
          end
        end
        HOLDOFF: begin
          if (startOfFrame) begin
            if (frame_cnt <= 4'd1) begin
              frame_cnt     <= '0;
              holdoffActive <= 1'b0;
              state         <= READY;
            end else begin
              frame_cnt <= frame_cnt - 4'd1;
            end
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_monster_collision_detector.sv
// -----------------------------------------------------------------------------
// tb_monster_collision_detector
//
// Self-checking bench for monster_collision_detector. A frame-level reference
// model keeps the edge codes of the current frame in a queue and reduces it
// at each publish; player holdoff is modelled as a count of frame starts
// since the last accepted hit. Every cycle all outputs are compared.
// -----------------------------------------------------------------------------
module tb_monster_collision_detector;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof, mon, wall, plr;
  logic [3:0] code;
  logic       mwh, ph, ha;
  logic [3:0] whc;
  logic [7:0] hcnt;

  int tests  = 0;
  int errors = 0;

  // reference model state
  logic [3:0] frame_codes[$];
  logic       exp_mwh;
  logic [3:0] exp_code;
  logic       exp_ph;
  logic       exp_ha;
  int         exp_hits;
  bit         hit_active;
  int         sofs_since_hit;

  monster_collision_detector #(.HOLDOFF_FRAMES(H), .EDGE_CODE_W(4)) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (sof),
    .monsterDrawingRequest(mon),
    .monsterHitEdgeCode   (code),
    .wallDrawingRequest   (wall),
    .playerDrawingRequest (plr),
    .monsterWallHit       (mwh),
    .wallHitEdgeCode      (whc),
    .playerHit            (ph),
    .holdoffActive        (ha),
    .hitCount             (hcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] outs_now();
    return {mwh, whc, ph, ha, hcnt};
  endfunction

  function automatic logic [14:0] outs_exp();
    return {exp_mwh, exp_code, exp_ph, exp_ha, 8'(exp_hits)};
  endfunction

  task automatic model_reset();
    frame_codes.delete();
    exp_mwh        = 1'b0;
    exp_code       = 4'h0;
    exp_ph         = 1'b0;
    exp_ha         = 1'b0;
    exp_hits       = 0;
    hit_active     = 1'b0;
    sofs_since_hit = 0;
  endtask

  // Drive one pixel, advance the model, then compare after the clock edge.
  task automatic step(input logic s, input logic m, input logic [3:0] c,
                      input logic w, input logic p, input string tag);
    logic [3:0] q_or;
    bit         ready;
    sof = s; mon = m; code = c; wall = w; plr = p;

    if (s) begin
      q_or = 4'h0;
      foreach (frame_codes[i]) q_or |= frame_codes[i];
      exp_mwh  = (frame_codes.size() > 0);
      exp_code = q_or;
      frame_codes.delete();
    end else begin
      exp_mwh = 1'b0;
    end
    if (m && w) frame_codes.push_back(c);

    ready = !hit_active || (sofs_since_hit >= H);
    if (s && hit_active) sofs_since_hit++;
    exp_ph = 1'b0;
    if (ready && m && p) begin
      exp_ph         = 1'b1;
      exp_hits       = (exp_hits < 255) ? exp_hits + 1 : 255;
      hit_active     = 1'b1;
      sofs_since_hit = 0;
    end
    exp_ha = hit_active && (sofs_since_hit < H);

    @(posedge clk);
    #1;
    check(tag, 32'(outs_now()), 32'(outs_exp()));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, tag);
  endtask

  task automatic apply_reset();
    #2 resetN = 1'b0;
    sof = 1'b0; mon = 1'b0; code = 4'h0; wall = 1'b0; plr = 1'b0;
    #1;
    check("reset_async_outs", 32'(outs_now()), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("reset_held_outs", 32'(outs_now()), 32'h0);
    resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    sof = 1'b0; mon = 1'b0; code = 4'h0; wall = 1'b0; plr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(outs_now()), 32'h0);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // codes 8, 2, 0 overlap; monster-only pixel code 1 must not count
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "f0_sof");
    step(1'b0, 1'b1, 4'h8, 1'b1, 1'b0, "f0_ov8");
    step(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, "f0_mon_only");
    step(1'b0, 1'b0, 4'h4, 1'b1, 1'b0, "f0_wall_only");
    step(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, "f0_ov2");
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, "f0_ov0");
    idle(3, "f0_idle");
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "f1_sof");
    check("publish_A_pulse", 32'(mwh), 32'h1);
    check("publish_A_code", 32'(whc), 32'hA);
    idle(5, "f1_hold");
    check("publish_A_held", 32'(whc), 32'hA);
    check("publish_A_single", 32'(mwh), 32'h0);

    // empty frame publishes nothing
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "f2_sof");
    check("empty_pulse", 32'(mwh), 32'h0);
    check("empty_code", 32'(whc), 32'h0);

    // code-0-only frame still pulses
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, "f2_ov0");
    idle(2, "f2_idle");
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "f3_sof");
    check("zero_code_pulse", 32'(mwh), 32'h1);
    check("zero_code_value", 32'(whc), 32'h0);

    // overlap on startOfFrame belongs to the new frame
    step(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, "f3_ov1");
    step(1'b1, 1'b1, 4'h4, 1'b1, 1'b0, "f4_sof_ov4");
    check("sof_ov_excluded", 32'(whc), 32'h1);
    idle(3, "f4_idle");
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "f5_sof");
    check("sof_ov_next", 32'(whc), 32'h4);
    check("sof_ov_next_pulse", 32'(mwh), 32'h1);

    // holdoff scenario from a clean reset
    apply_reset();
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "h0_sof");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, "h0_run");
    idle(2, "h0_idle");
    check("h0_holdoff", 32'(ha), 32'h1);
    for (int f = 1; f <= 3; f++) begin
      step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "hf_sof");
      step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, "hf_ov");
      idle(2, "hf_idle");
      check("hf_holdoff", 32'(ha), 32'h1);
    end
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, "h4_sof_ov");
    check("h4_released", 32'(ha), 32'h0);
    check("h4_ignored", 32'(ph), 32'h0);
    idle(3, "h4_idle");
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "h5_sof");
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, "h5_ov");
    check("h5_second_hit", 32'(ph), 32'h1);
    check("h5_hitcount", 32'(hcnt), 32'd2);

    // randomized mix of frames and overlaps
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0),
           4'($urandom), $urandom_range(0, 1) == 1, ($urandom_range(0, 5) == 0), "rand");
    end

    // reset during holdoff with pending accumulator F
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "r_sof");
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, "r_hit");
    step(1'b0, 1'b1, 4'h8, 1'b1, 1'b0, "r_ov8");
    step(1'b0, 1'b1, 4'h4, 1'b1, 1'b0, "r_ov4");
    step(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, "r_ov2");
    step(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, "r_ov1");
    check("r_in_holdoff", 32'(ha), 32'h1);
    apply_reset();
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, "r_after_hit");
    check("r_hit_after_reset", 32'(ph), 32'h1);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "r_publish");
    check("r_publish_code", 32'(whc), 32'h0);
    check("r_publish_pulse", 32'(mwh), 32'h0);

    // saturation: overlap on every pixel over many short frames
    for (int f = 0; f < 1150; f++) begin
      step(1'b1, 1'b1, 4'($urandom), $urandom_range(0, 1) == 1, 1'b1, "sat_sof");
      step(1'b0, 1'b1, 4'($urandom), $urandom_range(0, 1) == 1, 1'b1, "sat_pix");
    end
    check("sat_hitcount", 32'(hcnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Hard bound on simulated time so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
